// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge threshold scheduler.
package edge_pkg;

    localparam int unsigned CONV_W_DEF       = 29;
    localparam int unsigned SQRT_IN_W_DEF    = 60;
    localparam int unsigned SQRT_OUT_W_DEF   = 30;
    localparam int unsigned WINDOW_COUNT_DEF = 9;
    localparam int unsigned PIX_W_DEF        = 24;

    // Pixel levels; replicated across the full pixel width by users.
    localparam logic PIX_BLACK = 1'b0;
    localparam logic PIX_WHITE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StSqrtWait,
        StThresh,
        StEmit
    } state_e;

endpackage

// File: rtl/grad_sq_sum.sv
// Combinational |x|^2 + |y|^2 for two's-complement gradients.
// SUM_W must be at least 2*CONV_W+1 so the sum never truncates.
module grad_sq_sum
    import edge_pkg::*;
#(
    parameter int unsigned CONV_W = CONV_W_DEF,
    parameter int unsigned SUM_W  = SQRT_IN_W_DEF
) (
    input  logic [CONV_W-1:0] grad_x_i,
    input  logic [CONV_W-1:0] grad_y_i,
    output logic [SUM_W-1:0]  sum_sq_o
);

    localparam int unsigned SQ_W = 2 * CONV_W;

    logic [CONV_W-1:0] abs_x;
    logic [CONV_W-1:0] abs_y;
    logic [SQ_W-1:0]   sq_x;
    logic [SQ_W-1:0]   sq_y;

    // Magnitude as unsigned CONV_W so the most negative value maps to 2^(CONV_W-1).
    always_comb begin
        abs_x    = grad_x_i[CONV_W-1] ? ((~grad_x_i) + CONV_W'(1)) : grad_x_i;
        abs_y    = grad_y_i[CONV_W-1] ? ((~grad_y_i) + CONV_W'(1)) : grad_y_i;
        sq_x     = SQ_W'(abs_x) * SQ_W'(abs_x);
        sq_y     = SQ_W'(abs_y) * SQ_W'(abs_y);
        sum_sq_o = SUM_W'(sq_x) + SUM_W'(sq_y);
    end

endmodule

// File: rtl/edge_threshold_sched.sv
// Gathers a window of gradient magnitudes via an external shared root unit,
// thresholds each against the window mean and streams binary pixels.
module edge_threshold_sched
    import edge_pkg::*;
#(
    parameter int unsigned CONV_W       = CONV_W_DEF,
    parameter int unsigned SQRT_IN_W    = SQRT_IN_W_DEF,
    parameter int unsigned SQRT_OUT_W   = SQRT_OUT_W_DEF,
    parameter int unsigned WINDOW_COUNT = WINDOW_COUNT_DEF,
    parameter int unsigned PIX_W        = PIX_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  grad_valid_i,
    output logic                  grad_ready_o,
    input  logic [CONV_W-1:0]     grad_x_i,
    input  logic [CONV_W-1:0]     grad_y_i,
    output logic                  sqrt_start_o,
    output logic [SQRT_IN_W-1:0]  sqrt_num_o,
    input  logic                  sqrt_done_i,
    input  logic [SQRT_OUT_W-1:0] sqrt_sq_i,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic [PIX_W-1:0]      pix_data_o,
    output logic                  pix_last_o,
    output logic                  busy_o
);

    localparam int unsigned SUM_W = SQRT_OUT_W + $clog2(WINDOW_COUNT);
    localparam int unsigned IDX_W = $clog2(WINDOW_COUNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_COUNT - 1);

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [SUM_W-1:0]        sum_q;
    logic [SQRT_OUT_W-1:0]   thr_q;
    logic [SQRT_OUT_W-1:0]   mag_q [WINDOW_COUNT];
    logic                    grad_ready_q;
    logic                    sqrt_start_q;
    logic [SQRT_IN_W-1:0]    sqrt_num_q;
    logic                    pix_valid_q;
    logic [PIX_W-1:0]        pix_data_q;
    logic                    pix_last_q;
    logic                    busy_q;

    logic [SQRT_IN_W-1:0]    sum_sq;
    logic [SQRT_OUT_W-1:0]   thr_calc;
    logic [IDX_W-1:0]        idx_nxt;

    grad_sq_sum #(
        .CONV_W (CONV_W),
        .SUM_W  (SQRT_IN_W)
    ) u_grad_sq_sum (
        .grad_x_i (grad_x_i),
        .grad_y_i (grad_y_i),
        .sum_sq_o (sum_sq)
    );

    // Strictly above the mean is an edge (black); otherwise background (white).
    function automatic logic [PIX_W-1:0] pix_of(input logic [SQRT_OUT_W-1:0] mag,
                                                input logic [SQRT_OUT_W-1:0] thr);
        return (mag > thr) ? {PIX_W{PIX_BLACK}} : {PIX_W{PIX_WHITE}};
    endfunction

    // Mean of the window and the index of the following pixel.
    always_comb begin
        thr_calc = SQRT_OUT_W'(sum_q / SUM_W'(WINDOW_COUNT));
        idx_nxt  = idx_q + IDX_W'(1);
    end

    // Main FSM with all externally visible outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            sum_q        <= '0;
            thr_q        <= '0;
            grad_ready_q <= 1'b0;
            sqrt_start_q <= 1'b0;
            sqrt_num_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sqrt_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        state_q      <= StAccept;
                        grad_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                StAccept: begin
                    if (grad_valid_i && grad_ready_q) begin
                        sqrt_num_q   <= sum_sq;
                        sqrt_start_q <= 1'b1;
                        grad_ready_q <= 1'b0;
                        state_q      <= StSqrtWait;
                    end
                end
                StSqrtWait: begin
                    if (sqrt_done_i) begin
                        sum_q <= sum_q + SUM_W'(sqrt_sq_i);
                        idx_q <= idx_nxt;
                        if (idx_q == LAST_IDX) begin
                            state_q <= StThresh;
                        end else begin
                            state_q      <= StAccept;
                            grad_ready_q <= 1'b1;
                        end
                    end
                end
                StThresh: begin
                    // First pixel uses the freshly computed mean, not the stale thr_q.
                    thr_q       <= thr_calc;
                    idx_q       <= '0;
                    state_q     <= StEmit;
                    pix_valid_q <= 1'b1;
                    pix_data_q  <= pix_of(mag_q[0], thr_calc);
                    pix_last_q  <= (LAST_IDX == '0);
                end
                StEmit: begin
                    if (pix_ready_i) begin
                        if (pix_last_q) begin
                            sum_q       <= '0;
                            idx_q       <= '0;
                            pix_valid_q <= 1'b0;
                            pix_data_q  <= '0;
                            pix_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            idx_q      <= idx_nxt;
                            pix_data_q <= pix_of(mag_q[idx_nxt], thr_q);
                            pix_last_q <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Magnitude store; unreset since every entry is rewritten before it is read.
    always_ff @(posedge clk_i) begin
        if (state_q == StSqrtWait && sqrt_done_i) begin
            mag_q[idx_q] <= sqrt_sq_i;
        end
    end

    assign grad_ready_o = grad_ready_q;
    assign sqrt_start_o = sqrt_start_q;
    assign sqrt_num_o   = sqrt_num_q;
    assign pix_valid_o  = pix_valid_q;
    assign pix_data_o   = pix_data_q;
    assign pix_last_o   = pix_last_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_edge_threshold_sched.sv
// Bench for edge_threshold_sched: window model, root-unit responder, pixel scoreboard.
module tb_edge_threshold_sched;

    localparam int CW  = 29;
    localparam int SIW = 60;
    localparam int SOW = 30;
    localparam int WC  = 9;
    localparam int PW  = 24;

    typedef logic [PW:0] pix_t;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           enable_i;
    logic           grad_valid_i;
    logic           grad_ready_o;
    logic [CW-1:0]  grad_x_i;
    logic [CW-1:0]  grad_y_i;
    logic           sqrt_start_o;
    logic [SIW-1:0] sqrt_num_o;
    logic           sqrt_done_i;
    logic [SOW-1:0] sqrt_sq_i;
    logic           pix_valid_o;
    logic           pix_ready_i;
    logic [PW-1:0]  pix_data_o;
    logic           pix_last_o;
    logic           busy_o;

    always #5 clk_i = ~clk_i;

    edge_threshold_sched #(
        .CONV_W       (CW),
        .SQRT_IN_W    (SIW),
        .SQRT_OUT_W   (SOW),
        .WINDOW_COUNT (WC),
        .PIX_W        (PW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .grad_valid_i (grad_valid_i),
        .grad_ready_o (grad_ready_o),
        .grad_x_i     (grad_x_i),
        .grad_y_i     (grad_y_i),
        .sqrt_start_o (sqrt_start_o),
        .sqrt_num_o   (sqrt_num_o),
        .sqrt_done_i  (sqrt_done_i),
        .sqrt_sq_i    (sqrt_sq_i),
        .pix_valid_o  (pix_valid_o),
        .pix_ready_i  (pix_ready_i),
        .pix_data_o   (pix_data_o),
        .pix_last_o   (pix_last_o),
        .busy_o       (busy_o)
    );

    int tests = 0;
    int fails = 0;

    pix_t           pix_q[$];
    logic [SIW-1:0] num_q[$];
    longint         xs[WC];
    longint         ys[WC];
    int             lat_mode = 0;   // 0: latency 1, 1: table, 2: fixed 20
    int             lat_k = 0;
    int             lat_tab[10] = '{1, 20, 3, 7, 2, 15, 1, 11, 5, 9};
    bit             spur_en = 1'b0;
    int             stall_at = -1;
    int             stall_rem = 0;
    logic [PW-1:0]  pix_log[16];
    int             log_n = 0;
    int             last_at = -1;
    logic [SIW-1:0] num_log[16];
    int             num_n = 0;
    longint         thr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] isqrt(input logic [63:0] n);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= n) r = t;
        end
        return r;
    endfunction

    function automatic longint sq_sum(input longint x, input longint y);
        longint ax;
        longint ay;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        return ax * ax + ay * ay;
    endfunction

    // Expected pixels for the window held in xs/ys; returns the mean threshold.
    task automatic model_window(output longint t_out);
        longint mags[WC];
        longint sum;
        pix_t   e;
        sum = 0;
        for (int i = 0; i < WC; i++) begin
            mags[i] = longint'(isqrt(64'(sq_sum(xs[i], ys[i]))));
            sum += mags[i];
        end
        t_out = sum / WC;
        for (int i = 0; i < WC; i++) begin
            e = {(i == WC - 1) ? 1'b1 : 1'b0, (mags[i] > t_out) ? 24'h000000 : 24'hFFFFFF};
            pix_q.push_back(e);
        end
    endtask

    task automatic send_pair(input int i);
        int guard;
        guard = 0;
        grad_x_i     = CW'(xs[i]);
        grad_y_i     = CW'(ys[i]);
        grad_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (grad_ready_o) break;
            guard++;
            if (guard > 500) begin
                tests++;
                fails++;
                $display("FAIL grad_handshake: got no grad_ready, expected it within 500 cycles");
                grad_valid_i = 1'b0;
                return;
            end
        end
        num_q.push_back(SIW'(sq_sum(xs[i], ys[i])));
        @(posedge clk_i);
        #1;
        grad_valid_i = 1'b0;
    endtask

    task automatic wait_pixels_drained();
        int guard;
        guard = 0;
        while (pix_q.size() != 0 && guard < 2000) begin
            @(negedge clk_i);
            guard++;
        end
        tests++;
        if (pix_q.size() != 0) begin
            fails++;
            $display("FAIL window_drain: got %0d pixels outstanding, expected 0", pix_q.size());
            pix_q.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_window(input bit drop_en, output longint t_out);
        log_n   = 0;
        last_at = -1;
        num_n   = 0;
        model_window(t_out);
        for (int i = 0; i < WC; i++) begin
            send_pair(i);
            if (drop_en && i == 0) enable_i = 1'b0;
        end
        wait_pixels_drained();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_grad_ready"}, 64'(grad_ready_o), 64'd0);
        check({tag, "_sqrt_start"}, 64'(sqrt_start_o), 64'd0);
        check({tag, "_sqrt_num"}, 64'(sqrt_num_o), 64'd0);
        check({tag, "_pix_valid"}, 64'(pix_valid_o), 64'd0);
        check({tag, "_pix_last"}, 64'(pix_last_o), 64'd0);
        check({tag, "_pix_data"}, 64'(pix_data_o), 64'd0);
    endtask

    // Shared root unit: floor square root after a configurable latency.
    initial begin
        bit             pend;
        int             cnt;
        logic [SIW-1:0] held;
        logic [63:0]    r;
        pend        = 1'b0;
        cnt         = 0;
        held        = '0;
        sqrt_done_i = 1'b0;
        sqrt_sq_i   = '0;
        forever begin
            @(posedge clk_i);
            #1;
            sqrt_done_i = 1'b0;
            if (!rst_ni) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("sqrt_num_hold", 64'(sqrt_num_o), 64'(held));
                check("sqrt_start_pulse", 64'(sqrt_start_o), 64'd0);
                cnt--;
                if (cnt <= 0) begin
                    r           = isqrt(64'(held));
                    sqrt_sq_i   = r[SOW-1:0];
                    sqrt_done_i = 1'b1;
                    pend        = 1'b0;
                end
            end else if (sqrt_start_o) begin
                held = sqrt_num_o;
                if (num_n < 16) num_log[num_n] = held;
                num_n++;
                if (num_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sqrt_unexpected: got start with num 0x%0h, expected none", held);
                end else begin
                    check("sqrt_num", 64'(held), 64'(num_q.pop_front()));
                end
                pend = 1'b1;
                cnt  = (lat_mode == 1) ? lat_tab[lat_k % 10] : (lat_mode == 2) ? 20 : 1;
                lat_k++;
            end else if (spur_en && grad_ready_o) begin
                sqrt_sq_i   = '1;
                sqrt_done_i = 1'b1;
            end
        end
    end

    // Sink back-pressure: hold pix_ready low for stall_rem cycles on pixel stall_at.
    initial begin
        pix_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (pix_valid_o && log_n == stall_at && stall_rem > 0) begin
                pix_ready_i = 1'b0;
                stall_rem--;
            end else begin
                pix_ready_i = 1'b1;
            end
        end
    end

    // Scoreboard: every presented pixel must equal the head of the expected queue.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && pix_valid_o) begin
                if (pix_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pix_unexpected: got pixel 0x%0h, expected none", pix_data_o);
                end else begin
                    e = pix_q[0];
                    check("pix_data", 64'(pix_data_o), 64'(e[PW-1:0]));
                    check("pix_last", 64'(pix_last_o), 64'(e[PW]));
                    if (pix_ready_i) begin
                        void'(pix_q.pop_front());
                        if (log_n < 16) pix_log[log_n] = pix_data_o;
                        if (pix_last_o) last_at = log_n;
                        log_n++;
                    end
                end
            end
        end
    end

    initial begin
        rst_ni       = 1'b0;
        enable_i     = 1'b0;
        grad_valid_i = 1'b0;
        grad_x_i     = '0;
        grad_y_i     = '0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        enable_i = 1'b1;

        // Uniform window: every magnitude equals the mean, so all white.
        for (int i = 0; i < WC; i++) begin xs[i] = 3; ys[i] = 4; end
        run_window(1'b0, thr);
        check("w1_thr_model", 64'(thr), 64'd5);
        check("w1_count", 64'(log_n), 64'd9);
        check("w1_last_at", 64'(last_at), 64'd8);
        check("w1_pix0", 64'(pix_log[0]), 64'hFFFFFF);
        check("w1_pix8", 64'(pix_log[8]), 64'hFFFFFF);

        // Single strong edge among zeros.
        for (int i = 0; i < WC; i++) begin xs[i] = 0; ys[i] = 0; end
        xs[0] = 6; ys[0] = 8;
        run_window(1'b0, thr);
        check("w2_thr_model", 64'(thr), 64'd1);
        check("w2_pix0", 64'(pix_log[0]), 64'h000000);
        check("w2_pix1", 64'(pix_log[1]), 64'hFFFFFF);
        check("w2_pix8", 64'(pix_log[8]), 64'hFFFFFF);

        // Most negative gradient and a negative pair.
        for (int i = 0; i < WC; i++) begin xs[i] = 0; ys[i] = 0; end
        xs[0] = -268435456;
        xs[1] = -3; ys[1] = -4;
        run_window(1'b0, thr);
        check("w3_num_min", 64'(num_log[0]), 64'h0100_0000_0000_0000);
        check("w3_num_neg", 64'(num_log[1]), 64'd25);
        check("w3_pix0", 64'(pix_log[0]), 64'h000000);
        check("w3_pix1", 64'(pix_log[1]), 64'hFFFFFF);

        // Back-pressure on pixel 3; mags 0..8, mean 4.
        for (int i = 0; i < WC; i++) begin xs[i] = i; ys[i] = 0; end
        stall_at  = 3;
        stall_rem = 5;
        run_window(1'b0, thr);
        stall_at  = -1;
        check("w4_stall_used", 64'(stall_rem), 64'd0);
        check("w4_count", 64'(log_n), 64'd9);
        check("w4_pix3", 64'(pix_log[3]), 64'hFFFFFF);
        check("w4_pix4", 64'(pix_log[4]), 64'hFFFFFF);
        check("w4_pix5", 64'(pix_log[5]), 64'h000000);

        // Varied root latency, spurious done pulses, enable dropped after pair 0.
        // Mags 13*i, mean 52: pixel 4 sits exactly on the threshold.
        for (int i = 0; i < WC; i++) begin xs[i] = 5 * i; ys[i] = -12 * i; end
        lat_mode = 1;
        spur_en  = 1'b1;
        run_window(1'b1, thr);
        check("w5_thr_model", 64'(thr), 64'd52);
        check("w5_pix4", 64'(pix_log[4]), 64'hFFFFFF);
        check("w5_pix5", 64'(pix_log[5]), 64'h000000);
        check("w5_count", 64'(log_n), 64'd9);
        repeat (5) @(negedge clk_i);
        check("w5_idle_busy", 64'(busy_o), 64'd0);
        check("w5_idle_ready", 64'(grad_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        spur_en  = 1'b0;
        enable_i = 1'b1;

        // Reset while waiting on the root of pair 4.
        lat_mode = 2;
        for (int i = 0; i < WC; i++) begin xs[i] = 30; ys[i] = 40; end
        for (int i = 0; i < 5; i++) send_pair(i);
        repeat (2) @(posedge clk_i);
        #1;
        check("w6_busy_pre", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("midreset");
        pix_q.delete();
        num_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        lat_mode = 0;
        for (int i = 0; i < WC; i++) begin xs[i] = 0; ys[i] = 0; end
        xs[7] = 3; ys[7] = 4;
        xs[8] = 6; ys[8] = 8;
        run_window(1'b0, thr);
        check("w7_thr_model", 64'(thr), 64'd1);
        check("w7_pix0", 64'(pix_log[0]), 64'hFFFFFF);
        check("w7_pix7", 64'(pix_log[7]), 64'h000000);
        check("w7_pix8", 64'(pix_log[8]), 64'h000000);
        check("w7_last_at", 64'(last_at), 64'd8);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edge_threshold_sched.md
EDGE_THRESHOLD_SCHED -- requirements
Module: edge_threshold_sched

Interface
REQ-001 Parameter CONV_W, default 29, gradient width (two's complement).
REQ-002 Parameter SQRT_IN_W, default 60, radicand width.
REQ-003 Parameter SQRT_OUT_W, default 30, root width.
REQ-004 Parameter WINDOW_COUNT, default 9, magnitudes per window.
REQ-005 Parameter PIX_W, default 24, output pixel width.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-008 enable  input  1  permits leaving IDLE.
REQ-009 grad_valid  input  1; grad_ready  output  1  gradient handshake.
REQ-010 grad_x, grad_y  input  CONV_W each  signed Ix, Iy.
REQ-011 sqrt_start  output  1  one-cycle request pulse to the shared root unit.
REQ-012 sqrt_num  output  SQRT_IN_W  radicand, held stable from sqrt_start until sqrt_done.
REQ-013 sqrt_done  input  1  one-cycle pulse, sqrt_sq valid.
REQ-014 sqrt_sq  input  SQRT_OUT_W  root result.
REQ-015 pix_valid  output  1; pix_ready  input  1  pixel handshake.
REQ-016 pix_data  output  PIX_W  binary pixel; pix_last  output  1  final pixel of window.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCEPT, SQRT_WAIT, THRESH, EMIT.
REQ-019 IDLE -> ACCEPT on the cycle enable=1; grad_ready SHALL be 1 only in ACCEPT.
REQ-020 On grad_valid&&grad_ready: sqrt_num <= |grad_x|^2 + |grad_y|^2 (abs as unsigned CONV_W, squares zero-extended, no truncation), sqrt_start <= 1 for exactly one cycle, state -> SQRT_WAIT.
REQ-021 In SQRT_WAIT on sqrt_done: mag[idx] <= sqrt_sq, sum <= sum + sqrt_sq, idx <= idx+1; -> THRESH if idx was WINDOW_COUNT-1, else ACCEPT.
REQ-022 sqrt_done outside SQRT_WAIT SHALL be ignored; sqrt_done is never expected in the sqrt_start cycle.
REQ-023 sum width SHALL be SQRT_OUT_W + clog2(WINDOW_COUNT); no overflow possible.
REQ-024 THRESH (one cycle): thr <= floor(sum / WINDOW_COUNT), idx <= 0, -> EMIT.
REQ-025 EMIT: pix_valid=1; pix_data = all-zeros if mag[idx] > thr (strict), else all-ones; pix_last = (idx == WINDOW_COUNT-1).
REQ-026 pix_data/pix_last SHALL remain stable while pix_valid && !pix_ready.
REQ-027 On pix_ready in EMIT: idx++ ; on last pixel sum <= 0, idx <= 0, -> IDLE.
REQ-028 Dropping enable mid-window SHALL NOT abort the window; it only blocks IDLE -> ACCEPT.
REQ-029 Throughput: one pair per sqrt round trip; no new pair accepted while SQRT_WAIT.

Reset
REQ-030 While reset=0: state=IDLE, idx=0, sum=0, thr=0, sqrt_num=0, and grad_ready, sqrt_start, pix_valid, pix_last, busy all 0, pix_data=0.
REQ-031 Reset mid-window SHALL discard all partial results; the next window starts at idx 0; mag storage need not be cleared.

Structure
REQ-032 Shared package edge_pkg SHALL hold state enum, default widths, and PIX_BLACK/PIX_WHITE constants.
REQ-033 One sub-module grad_sq_sum SHALL implement abs and sum-of-squares combinationally.
REQ-034 The root unit SHALL stay external to allow sharing between instances.

Verification
REQ-035 Nine pairs (3,4), sqrt model returns 5 -> sum 45, thr 5, nine pixels 0xFFFFFF, pix_last on ninth.
REQ-036 Pair0 (6,8), pairs1-8 (0,0) -> sum 10, thr 1, pixel0 0x000000, pixels1-8 0xFFFFFF.
REQ-037 grad_x=0x10000000 (min), grad_y=0 -> sqrt_num = 2^56; (-3,-4) -> sqrt_num = 25.
REQ-038 pix_ready low 5 cycles on pixel 3 -> pix_data/pix_last unchanged, no pixel skipped or duplicated.
REQ-039 reset pulled low in SQRT_WAIT of pair 4, released -> all outputs at reset values; new 9-pair window yields correct thr unaffected by prior sum.
REQ-040 Sqrt model latency varied 1..20 cycles, spurious sqrt_done in ACCEPT -> sqrt_num stable until done, spurious pulse ignored, results identical.
